// File: rtl/ec_scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer for a shared combinational projective point ALU.
// Define SCALAR_CT_EN for the constant-time ladder (ADD after every DBL, unset bits go to a dummy register).
module ec_scalar_mult_ctrl #(
   parameter int              KW     = 8,
   parameter int              PW     = 12,
   parameter logic [PW-1:0]   INF_PT = 12'h010
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] k,
   input  logic [PW-1:0] P,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] R,
   output logic          r_inf,
   output logic          alu_op,
   output logic [PW-1:0] alu_a,
   output logic [PW-1:0] alu_b,
   input  logic [PW-1:0] alu_r
);

   localparam int              IW      = (KW > 1) ? $clog2(KW) : 1;
   localparam logic [IW-1:0]   IDX_TOP = IW'(KW - 1);

   typedef enum logic [1:0] {S_IDLE, S_DBL, S_ADD, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [KW-1:0] kq, kq_nxt;
   logic [PW-1:0] pq, pq_nxt;
   logic [PW-1:0] q, q_nxt;
   logic          inf, inf_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [PW-1:0] r_reg, r_nxt;
   logic          r_inf_reg, r_inf_nxt;
   logic          finish;
`ifdef SCALAR_CT_EN
   logic [PW-1:0] d_reg, d_nxt;
`endif

   assign alu_a = q;
   assign alu_b = pq;
   assign R     = r_reg;
   assign r_inf = r_inf_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         kq        <= '0;
         pq        <= '0;
         q         <= '0;
         inf       <= 1'b1;
         idx       <= '0;
         r_reg     <= INF_PT;
         r_inf_reg <= 1'b1;
`ifdef SCALAR_CT_EN
         d_reg     <= '0;
`endif
      end else begin
         state     <= state_nxt;
         kq        <= kq_nxt;
         pq        <= pq_nxt;
         q         <= q_nxt;
         inf       <= inf_nxt;
         idx       <= idx_nxt;
         r_reg     <= r_nxt;
         r_inf_reg <= r_inf_nxt;
`ifdef SCALAR_CT_EN
         d_reg     <= d_nxt;
`endif
      end
   end

   // While Q is infinity the ALU result is ignored: doubling keeps infinity, the first add loads P.
   always_comb begin
      state_nxt = state;
      kq_nxt    = kq;
      pq_nxt    = pq;
      q_nxt     = q;
      inf_nxt   = inf;
      idx_nxt   = idx;
      r_nxt     = r_reg;
      r_inf_nxt = r_inf_reg;
      finish    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      alu_op    = 1'b0;
`ifdef SCALAR_CT_EN
      d_nxt     = d_reg;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            done = (state == S_DONE);
            if (start) begin
               kq_nxt    = k;
               pq_nxt    = P;
               inf_nxt   = 1'b1;
               idx_nxt   = IDX_TOP;
               state_nxt = S_DBL;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_DBL: begin
            busy   = 1'b1;
            alu_op = 1'b1;
            if (!inf) q_nxt = alu_r;
`ifdef SCALAR_CT_EN
            state_nxt = S_ADD;
`else
            if (kq[idx])          state_nxt = S_ADD;
            else if (idx == '0)   finish = 1'b1;
            else begin
               idx_nxt   = idx - 1'b1;
               state_nxt = S_DBL;
            end
`endif
         end
         S_ADD: begin
            busy = 1'b1;
`ifdef SCALAR_CT_EN
            if (kq[idx]) begin
               if (inf) begin
                  q_nxt   = pq;
                  inf_nxt = 1'b0;
               end else begin
                  q_nxt = alu_r;
               end
            end else begin
               d_nxt = inf ? pq : alu_r;
            end
`else
            if (inf) begin
               q_nxt   = pq;
               inf_nxt = 1'b0;
            end else begin
               q_nxt = alu_r;
            end
`endif
            if (idx == '0) finish = 1'b1;
            else begin
               idx_nxt   = idx - 1'b1;
               state_nxt = S_DBL;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // Capture the final accumulator on the way into DONE so R is valid alongside the done pulse.
      if (finish) begin
         state_nxt = S_DONE;
         r_nxt     = inf_nxt ? INF_PT : q_nxt;
         r_inf_nxt = inf_nxt;
      end
   end

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Directed bench for ec_scalar_mult_ctrl with a behavioural point ALU and double-and-add reference model.
module tb_ec_scalar_mult_ctrl;

   localparam int KW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k;
   logic [11:0]   P;
   logic          busy;
   logic          done;
   logic [11:0]   R;
   logic          r_inf;
   logic          alu_op;
   logic [11:0]   alu_a;
   logic [11:0]   alu_b;
   logic [11:0]   alu_r;

   int vectors     = 0;
   int miscompares = 0;

   ec_scalar_mult_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .k(k), .P(P),
      .busy(busy), .done(done), .R(R), .r_inf(r_inf),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] pt_alu(input logic op, input logic [11:0] a, input logic [11:0] b);
      logic [3:0] x, y, z;
      if (op) begin
         x = a[3:0] * 4'd3 + a[7:4];
         y = a[7:4] ^ {a[2:0], a[3]};
         z = a[11:8] + a[3:0] + 4'd1;
      end else begin
         x = a[3:0] + b[3:0] + (a[11:8] ^ b[11:8]);
         y = a[7:4] ^ b[7:4] ^ 4'h5;
         z = a[11:8] + b[7:4];
      end
      return {z, y, x};
   endfunction

   assign alu_r = pt_alu(alu_op, alu_a, alu_b);

   function automatic logic [12:0] model(input logic [KW-1:0] kk, input logic [11:0] pp);
      logic [11:0] q;
      logic        inf;
      q   = '0;
      inf = 1'b1;
      for (int i = KW - 1; i >= 0; i--) begin
         if (!inf) q = pt_alu(1'b1, q, pp);
         if (kk[i]) begin
            if (inf) begin
               q   = pp;
               inf = 1'b0;
            end else begin
               q = pt_alu(1'b0, q, pp);
            end
         end
      end
      return inf ? {1'b1, 12'h010} : {1'b0, q};
   endfunction

   function automatic int exp_lat(input logic [KW-1:0] kk);
`ifdef SCALAR_CT_EN
      return 2 * KW + 1;
`else
      return KW + $countones(kk) + 1;
`endif
   endfunction

   task automatic run_op(input logic [KW-1:0] kk, input logic [11:0] pp,
                         output int lat, output logic [11:0] r, output logic ri);
      @(negedge clk);
      start = 1'b1;
      k     = kk;
      P     = pp;
      lat   = -1;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
      r  = R;
      ri = r_inf;
   endtask

   task automatic test_reset();
      int          lat;
      logic [11:0] r;
      logic        ri;
      int          pulses;
      rst = 1'b1; start = 1'b0; k = '0; P = '0;
      repeat (2) @(negedge clk);
      vectors += 7;
      if (busy !== 1'b0)      begin miscompares++; $display("[TB] FAIL rst_busy got %0b want 0", busy); end
      if (done !== 1'b0)      begin miscompares++; $display("[TB] FAIL rst_done got %0b want 0", done); end
      if (R !== 12'h010)      begin miscompares++; $display("[TB] FAIL rst_R got %h want 010", R); end
      if (r_inf !== 1'b1)     begin miscompares++; $display("[TB] FAIL rst_rinf got %0b want 1", r_inf); end
      if (alu_op !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_aluop got %0b want 0", alu_op); end
      if (alu_a !== 12'h000)  begin miscompares++; $display("[TB] FAIL rst_alua got %h want 000", alu_a); end
      if (alu_b !== 12'h000)  begin miscompares++; $display("[TB] FAIL rst_alub got %h want 000", alu_b); end
      rst = 1'b0;
      run_op(8'h01, 12'h1A3, lat, r, ri);
      vectors++;
      if (r !== 12'h1A3) begin miscompares++; $display("[TB] FAIL pre_reset_R got %h want 1a3", r); end
      // Launch a long op and abort it part-way through.
      pulses = 0;
      @(negedge clk);
      start = 1'b1; k = 8'hFF; P = 12'h2B4;
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin @(negedge clk); if (done) pulses++; end
      rst = 1'b1;
      repeat (2) begin @(negedge clk); if (done) pulses++; end
      vectors += 6;
      if (busy !== 1'b0)      begin miscompares++; $display("[TB] FAIL abort_busy got %0b want 0", busy); end
      if (done !== 1'b0)      begin miscompares++; $display("[TB] FAIL abort_done got %0b want 0", done); end
      if (R !== 12'h010)      begin miscompares++; $display("[TB] FAIL abort_R got %h want 010", R); end
      if (r_inf !== 1'b1)     begin miscompares++; $display("[TB] FAIL abort_rinf got %0b want 1", r_inf); end
      if (alu_a !== 12'h000)  begin miscompares++; $display("[TB] FAIL abort_alua got %h want 000", alu_a); end
      if (alu_b !== 12'h000)  begin miscompares++; $display("[TB] FAIL abort_alub got %h want 000", alu_b); end
      rst = 1'b0;
      repeat (30) begin @(negedge clk); if (done) pulses++; end
      vectors++;
      if (pulses !== 0) begin miscompares++; $display("[TB] FAIL abort_done_pulses got %0d want 0", pulses); end
   endtask

   task automatic test_k_zero();
      int          lat;
      logic [11:0] r;
      logic        ri;
      run_op(8'h00, 12'h7E2, lat, r, ri);
      vectors += 3;
      if (lat !== exp_lat(8'h00)) begin miscompares++; $display("[TB] FAIL k0_latency got %0d want %0d", lat, exp_lat(8'h00)); end
      if (r !== 12'h010)          begin miscompares++; $display("[TB] FAIL k0_R got %h want 010", r); end
      if (ri !== 1'b1)            begin miscompares++; $display("[TB] FAIL k0_rinf got %0b want 1", ri); end
   endtask

   task automatic test_k_one();
      int          lat;
      logic [11:0] r;
      logic        ri;
      run_op(8'h01, 12'h1A3, lat, r, ri);
      vectors += 3;
      if (lat !== exp_lat(8'h01)) begin miscompares++; $display("[TB] FAIL k1_latency got %0d want %0d", lat, exp_lat(8'h01)); end
      if (r !== 12'h1A3)          begin miscompares++; $display("[TB] FAIL k1_R got %h want 1a3", r); end
      if (ri !== 1'b0)            begin miscompares++; $display("[TB] FAIL k1_rinf got %0b want 0", ri); end
   endtask

   task automatic test_b5();
      logic [KW-1:0] kk;
      logic [11:0]   pp;
      logic [12:0]   m;
      logic          exp_ops[$];
      int            lat;
      int            op_bad;
      kk = 8'hB5;
      pp = 12'h5C7;
      m  = model(kk, pp);
      for (int i = KW - 1; i >= 0; i--) begin
         exp_ops.push_back(1'b1);
`ifdef SCALAR_CT_EN
         exp_ops.push_back(1'b0);
`else
         if (kk[i]) exp_ops.push_back(1'b0);
`endif
      end
      op_bad = 0;
      lat    = -1;
      @(negedge clk);
      start = 1'b1; k = kk; P = pp;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
         vectors++;
         if (c > exp_ops.size() || alu_op !== exp_ops[c-1]) begin
            miscompares++;
            op_bad++;
            $display("[TB] FAIL b5_aluop cycle %0d got %0b want %0b", c, alu_op,
                     (c > exp_ops.size()) ? 1'b0 : exp_ops[c-1]);
         end
      end
      vectors += 4;
      if (lat !== exp_lat(kk))   begin miscompares++; $display("[TB] FAIL b5_latency got %0d want %0d", lat, exp_lat(kk)); end
      if (R !== m[11:0])         begin miscompares++; $display("[TB] FAIL b5_R got %h want %h", R, m[11:0]); end
      if (r_inf !== m[12])       begin miscompares++; $display("[TB] FAIL b5_rinf got %0b want %0b", r_inf, m[12]); end
      if (alu_op !== 1'b0)       begin miscompares++; $display("[TB] FAIL b5_aluop_done got %0b want 0", alu_op); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] m1, m2;
      int          lat1, lat2, held_bad, pulses;
      m1 = model(8'h03, 12'h3D9);
      m2 = model(8'h02, 12'h0F6);
      lat1 = -1;
      @(negedge clk);
      start = 1'b1; k = 8'h03; P = 12'h3D9;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin lat1 = c; break; end
      end
      vectors += 2;
      if (lat1 !== exp_lat(8'h03)) begin miscompares++; $display("[TB] FAIL b2b_lat1 got %0d want %0d", lat1, exp_lat(8'h03)); end
      if (R !== m1[11:0])          begin miscompares++; $display("[TB] FAIL b2b_R1 got %h want %h", R, m1[11:0]); end
      // Hold start through the DONE cycle to chain the next command.
      start = 1'b1; k = 8'h02; P = 12'h0F6;
      @(negedge clk);
      start = 1'b0;
      vectors += 3;
      if (busy !== 1'b1)      begin miscompares++; $display("[TB] FAIL b2b_no_bubble busy got %0b want 1", busy); end
      if (done !== 1'b0)      begin miscompares++; $display("[TB] FAIL b2b_done_after got %0b want 0", done); end
      if (R !== m1[11:0])     begin miscompares++; $display("[TB] FAIL b2b_R_held got %h want %h", R, m1[11:0]); end
      held_bad = 0;
      lat2     = -1;
      for (int c = 2; c <= 64; c++) begin
         start = (c == 4);
         if (c == 4) begin k = 8'hFF; P = 12'hABC; end
         @(negedge clk);
         if (done) begin lat2 = c; break; end
         if (R !== m1[11:0]) held_bad++;
      end
      start = 1'b0;
      vectors += 4;
      if (held_bad !== 0)          begin miscompares++; $display("[TB] FAIL b2b_R_hold_cycles got %0d bad want 0", held_bad); end
      if (lat2 !== exp_lat(8'h02)) begin miscompares++; $display("[TB] FAIL b2b_lat2 got %0d want %0d", lat2, exp_lat(8'h02)); end
      if (R !== m2[11:0])          begin miscompares++; $display("[TB] FAIL b2b_R2 got %h want %h", R, m2[11:0]); end
      if (r_inf !== m2[12])        begin miscompares++; $display("[TB] FAIL b2b_rinf2 got %0b want %0b", r_inf, m2[12]); end
      pulses = 0;
      repeat (30) begin @(negedge clk); if (done) pulses++; end
      vectors += 2;
      if (pulses !== 0)  begin miscompares++; $display("[TB] FAIL b2b_extra_done got %0d want 0", pulses); end
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_busy got %0b want 0", busy); end
   endtask

   task automatic test_exhaustive();
      logic [11:0] pts[4];
      logic [12:0] m;
      int          lat;
      logic [11:0] r;
      logic        ri;
      pts[0] = 12'h1A3; pts[1] = 12'hFFF; pts[2] = 12'h000; pts[3] = 12'h8E5;
      for (int p = 0; p < 4; p++) begin
         for (int kv = 0; kv < 256; kv++) begin
            m = model(KW'(kv), pts[p]);
            run_op(KW'(kv), pts[p], lat, r, ri);
            vectors += 3;
            if (lat !== exp_lat(KW'(kv))) begin miscompares++; $display("[TB] FAIL exh_latency k=%0d P=%h got %0d want %0d", kv, pts[p], lat, exp_lat(KW'(kv))); end
            if (r !== m[11:0])            begin miscompares++; $display("[TB] FAIL exh_R k=%0d P=%h got %h want %h", kv, pts[p], r, m[11:0]); end
            if (ri !== m[12])             begin miscompares++; $display("[TB] FAIL exh_rinf k=%0d P=%h got %0b want %0b", kv, pts[p], ri, m[12]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_k_zero();
      test_k_one();
      test_b5();
      test_back_to_back();
      test_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
